// File: rtl/rob_pkg.sv
// Shared types and helpers for the N-way reorder buffer: the entry record and
// the branch outcome checks used at retire.
package rob_pkg;

    localparam int ROB_XLEN  = 32;
    localparam int ROB_ARN_W = 5;
    localparam int ROB_PRN_W = 6;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic [ROB_ARN_W-1:0] arn;
        logic [ROB_PRN_W-1:0] prn;
        logic                 reg_write;
        logic                 is_branch;
        logic [ROB_XLEN-1:0]  pc;
        logic                 pred_taken;
        logic [ROB_XLEN-1:0]  pred_target;
        logic                 act_taken;
        logic [ROB_XLEN-1:0]  act_target;
    } rob_entry_t;

    // A fall-through prediction only needs the direction to match.
    function automatic logic rob_mispredict(input rob_entry_t e);
        return e.is_branch &&
               ((e.act_taken != e.pred_taken) ||
                (e.act_taken && (e.act_target != e.pred_target)));
    endfunction

    function automatic logic [ROB_XLEN-1:0] rob_redirect(input rob_entry_t e);
        return e.act_taken ? e.act_target : (e.pc + ROB_XLEN'(4));
    endfunction

endpackage

// File: rtl/rob_nway_chk.sv
// Run-time checks on the ROB's upstream contract and internal bookkeeping;
// carries no functional logic.
module rob_nway_chk
    import rob_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int XLEN   = 32,
    parameter int ARN_W  = 5,
    parameter int PRN_W  = 6,
    parameter int CNT_W  = 6,
    parameter int SLOT_W = 1
) (
    input logic              clock,
    input logic              reset,
    input logic [WAYS-1:0]   dis_valid,
    input logic [CNT_W-1:0]  num_free,
    input logic              flush,
    input logic [WAYS-1:0]   ret_mask,
    input logic [SLOT_W-1:0] mp_slot,
    input logic              full
);

    function automatic logic [CNT_W-1:0] count_ones(input logic [WAYS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WAYS; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [WAYS-1:0] upto_mask(input logic [SLOT_W-1:0] k);
        logic [WAYS-1:0] m;
        m = '0;
        for (int i = 0; i < WAYS; i++) begin
            m[i] = (SLOT_W'(i) <= k);
        end
        return m;
    endfunction

    // Entry storage widths come from the package, so the parameters must agree.
    always @(posedge clock) begin
        if (!reset) begin
            assert (XLEN == ROB_XLEN && ARN_W == ROB_ARN_W && PRN_W == ROB_PRN_W)
                else $error("rob_nway: width parameters disagree with rob_pkg");
            if (!flush) begin
                assert (count_ones(dis_valid) <= num_free)
                    else $error("rob_nway: dispatch of %0d with %0d free",
                                count_ones(dis_valid), num_free);
            end
            assert (full == (num_free == '0))
                else $error("rob_nway: pointer full flag disagrees with num_free");
            if (flush) begin
                assert (ret_mask == upto_mask(mp_slot))
                    else $error("rob_nway: retire mask extends past mispredict");
            end
        end
    end

endmodule

// File: rtl/rob_retire_sel.sv
// Picks the contiguous run of completed entries at the head of the ROB and
// cuts it after the first mispredicting branch, which also drives the redirect.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SLOT_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  rob_entry_t          head_ent [WAYS],
    output logic [WAYS-1:0]     ret_mask,
    output logic                flush,
    output logic [ROB_XLEN-1:0] flush_pc,
    output logic [SLOT_W-1:0]   mp_slot
);

    logic open_s;

    // Walk the head window oldest-first; the run closes on the first
    // not-ready entry or right after a mispredicting branch.
    always_comb begin
        ret_mask = '0;
        flush    = 1'b0;
        flush_pc = '0;
        mp_slot  = '0;
        open_s   = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (open_s && head_ent[i].valid && head_ent[i].done) begin
                ret_mask[i] = 1'b1;
                if (rob_mispredict(head_ent[i])) begin
                    flush    = 1'b1;
                    flush_pc = rob_redirect(head_ent[i]);
                    mp_slot  = SLOT_W'(i);
                    open_s   = 1'b0;
                end else begin
                    open_s = open_s;
                end
            end else begin
                open_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: allocates, completes and retires up to WAYS entries
// per cycle, squashing everything when a retiring branch mispredicted.
module rob_nway
    import rob_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int DEPTH = 32,
    parameter int XLEN  = ROB_XLEN,
    parameter int ARN_W = ROB_ARN_W,
    parameter int PRN_W = ROB_PRN_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WAYS-1:0]        dis_valid,
    input  logic [WAYS*ARN_W-1:0]  dis_arn,
    input  logic [WAYS*PRN_W-1:0]  dis_prn,
    input  logic [WAYS-1:0]        dis_reg_write,
    input  logic [WAYS-1:0]        dis_is_branch,
    input  logic [WAYS*XLEN-1:0]   dis_pc,
    input  logic [WAYS-1:0]        dis_pred_taken,
    input  logic [WAYS*XLEN-1:0]   dis_pred_target,
    output logic [WAYS*IDX_W-1:0]  dis_idx,
    output logic [$clog2(DEPTH+1)-1:0] num_free,
    input  logic [WAYS-1:0]        cdb_valid,
    input  logic [WAYS*IDX_W-1:0]  cdb_idx,
    input  logic [WAYS-1:0]        cdb_taken,
    input  logic [WAYS*XLEN-1:0]   cdb_target,
    output logic [WAYS-1:0]        ret_valid,
    output logic [WAYS*ARN_W-1:0]  ret_arn,
    output logic [WAYS*PRN_W-1:0]  ret_prn,
    output logic [WAYS-1:0]        ret_reg_write,
    output logic                   flush,
    output logic [XLEN-1:0]        flush_pc
);

    localparam int PTR_W  = IDX_W + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    rob_entry_t       rob_q [DEPTH];
    rob_entry_t       rob_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] num_free_q, num_free_d;

    rob_entry_t        head_ent_s [WAYS];
    logic [WAYS-1:0]   ret_mask_s;
    logic              flush_s;
    logic [XLEN-1:0]   flush_pc_s;
    logic [SLOT_W-1:0] mp_slot_s;
    logic [CNT_W-1:0]  ndis_s, nret_s;
    logic              dis_ok_s;
    logic              full_s;

    // Head window and per-way counts; index arithmetic wraps in IDX_W bits.
    always_comb begin
        ndis_s = '0;
        nret_s = '0;
        for (int i = 0; i < WAYS; i++) begin
            head_ent_s[i] = rob_q[head_q[IDX_W-1:0] + IDX_W'(i)];
            ndis_s        = ndis_s + CNT_W'(dis_valid[i]);
            nret_s        = nret_s + CNT_W'(ret_mask_s[i]);
        end
        dis_ok_s = (ndis_s <= num_free_q);
        full_s   = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                   (head_q[IDX_W] != tail_q[IDX_W]);
    end

    rob_retire_sel #(
        .WAYS   (WAYS),
        .SLOT_W (SLOT_W)
    ) u_retire_sel (
        .head_ent (head_ent_s),
        .ret_mask (ret_mask_s),
        .flush    (flush_s),
        .flush_pc (flush_pc_s),
        .mp_slot  (mp_slot_s)
    );

    // Retire and dispatch-index outputs, straight from registered state.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            ret_arn[i*ARN_W +: ARN_W]  = head_ent_s[i].arn;
            ret_prn[i*PRN_W +: PRN_W]  = head_ent_s[i].prn;
            ret_reg_write[i]           = head_ent_s[i].reg_write;
            dis_idx[i*IDX_W +: IDX_W]  = tail_q[IDX_W-1:0] + IDX_W'(i);
        end
        ret_valid = ret_mask_s;
        flush     = flush_s;
        flush_pc  = flush_pc_s;
        num_free  = num_free_q;
    end

    // Next state: a squash wins over everything; otherwise completions,
    // retires and allocations touch disjoint entries and all apply.
    always_comb begin
        rob_d      = rob_q;
        head_d     = head_q + PTR_W'(nret_s);
        tail_d     = tail_q;
        num_free_d = num_free_q;
        if (flush_s) begin
            for (int e = 0; e < DEPTH; e++) begin
                rob_d[e].valid = 1'b0;
            end
            tail_d     = head_d;
            num_free_d = CNT_W'(DEPTH);
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (cdb_valid[w] && rob_q[cdb_idx[w*IDX_W +: IDX_W]].valid) begin
                    rob_d[cdb_idx[w*IDX_W +: IDX_W]].done       = 1'b1;
                    rob_d[cdb_idx[w*IDX_W +: IDX_W]].act_taken  = cdb_taken[w];
                    rob_d[cdb_idx[w*IDX_W +: IDX_W]].act_target = cdb_target[w*XLEN +: XLEN];
                end else begin
                    rob_d[cdb_idx[w*IDX_W +: IDX_W]] = rob_d[cdb_idx[w*IDX_W +: IDX_W]];
                end
            end
            for (int i = 0; i < WAYS; i++) begin
                if (ret_mask_s[i]) begin
                    rob_d[head_q[IDX_W-1:0] + IDX_W'(i)].valid = 1'b0;
                    rob_d[head_q[IDX_W-1:0] + IDX_W'(i)].done  = 1'b0;
                end else begin
                    rob_d[head_q[IDX_W-1:0] + IDX_W'(i)] = rob_d[head_q[IDX_W-1:0] + IDX_W'(i)];
                end
            end
            if (dis_ok_s) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (dis_valid[w]) begin
                        rob_d[tail_q[IDX_W-1:0] + IDX_W'(w)] = '{
                            valid:       1'b1,
                            done:        1'b0,
                            arn:         dis_arn[w*ARN_W +: ARN_W],
                            prn:         dis_prn[w*PRN_W +: PRN_W],
                            reg_write:   dis_reg_write[w],
                            is_branch:   dis_is_branch[w],
                            pc:          dis_pc[w*XLEN +: XLEN],
                            pred_taken:  dis_pred_taken[w],
                            pred_target: dis_pred_target[w*XLEN +: XLEN],
                            act_taken:   1'b0,
                            act_target:  '0
                        };
                    end else begin
                        rob_d[tail_q[IDX_W-1:0] + IDX_W'(w)] = rob_d[tail_q[IDX_W-1:0] + IDX_W'(w)];
                    end
                end
                tail_d     = tail_q + PTR_W'(ndis_s);
                num_free_d = num_free_q - ndis_s + nret_s;
            end else begin
                num_free_d = num_free_q + nret_s;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                rob_q[e] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            num_free_q <= CNT_W'(DEPTH);
        end else begin
            rob_q      <= rob_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            num_free_q <= num_free_d;
        end
    end

    rob_nway_chk #(
        .WAYS   (WAYS),
        .XLEN   (XLEN),
        .ARN_W  (ARN_W),
        .PRN_W  (PRN_W),
        .CNT_W  (CNT_W),
        .SLOT_W (SLOT_W)
    ) u_chk (
        .clock     (clock),
        .reset     (reset),
        .dis_valid (dis_valid),
        .num_free  (num_free_q),
        .flush     (flush_s),
        .ret_mask  (ret_mask_s),
        .mp_slot   (mp_slot_s),
        .full      (full_s)
    );

endmodule

// File: tb/tb_rob_nway.sv
// Self-checking bench for rob_nway: a directed vector table for the corner
// cases, then random traffic, all against an in-order queue model.
module tb_rob_nway;

    localparam int WAYS  = 2;
    localparam int DEPTH = 32;
    localparam int XLEN  = 32;
    localparam int ARN_W = 5;
    localparam int PRN_W = 6;
    localparam int IDX_W = 5;
    localparam int CNT_W = 6;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [WAYS-1:0]       dis_valid, dis_reg_write, dis_is_branch, dis_pred_taken;
    logic [WAYS*ARN_W-1:0] dis_arn, ret_arn;
    logic [WAYS*PRN_W-1:0] dis_prn, ret_prn;
    logic [WAYS*XLEN-1:0]  dis_pc, dis_pred_target, cdb_target;
    logic [WAYS*IDX_W-1:0] dis_idx, cdb_idx;
    logic [CNT_W-1:0]      num_free;
    logic [WAYS-1:0]       cdb_valid, cdb_taken, ret_valid, ret_reg_write;
    logic                  flush;
    logic [XLEN-1:0]       flush_pc;

    rob_nway #(.WAYS(WAYS), .DEPTH(DEPTH), .XLEN(XLEN), .ARN_W(ARN_W), .PRN_W(PRN_W)) dut (
        .clock(clock), .reset(reset),
        .dis_valid(dis_valid), .dis_arn(dis_arn), .dis_prn(dis_prn),
        .dis_reg_write(dis_reg_write), .dis_is_branch(dis_is_branch), .dis_pc(dis_pc),
        .dis_pred_taken(dis_pred_taken), .dis_pred_target(dis_pred_target),
        .dis_idx(dis_idx), .num_free(num_free),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .ret_valid(ret_valid), .ret_arn(ret_arn), .ret_prn(ret_prn), .ret_reg_write(ret_reg_write),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clock = ~clock;

    // Model: the live instructions in program order, oldest first.
    typedef struct {
        int         idx;
        logic [4:0] arn;
        logic [5:0] prn;
        bit         rw, br, pt, done, at;
        logic [31:0] pc, ptg, atg;
    } m_ent_t;

    m_ent_t      q[$];
    int          m_head = 0;
    bit   [1:0]  e_ret;
    int          e_nret;
    bit          e_flush;
    logic [31:0] e_fpc;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        bit          rst;
        int          ndis;
        bit          br0;
        bit          c0v;
        int          c0i;
        bit          c0t;
        logic [31:0] c0g;
        bit          c1v;
        int          c1i;
        bit   [1:0]  eret;
        int          efree;
        bit          efl;
        logic [31:0] efpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, int ndis, bit br0, bit c0v, int c0i, bit c0t,
                                logic [31:0] c0g, bit c1v, int c1i, bit [1:0] eret,
                                int efree, bit efl, logic [31:0] efpc);
        vec_t v;
        v.rst = rst; v.ndis = ndis; v.br0 = br0; v.c0v = c0v; v.c0i = c0i; v.c0t = c0t;
        v.c0g = c0g; v.c1v = c1v; v.c1i = c1i; v.eret = eret; v.efree = efree;
        v.efl = efl; v.efpc = efpc;
        return v;
    endfunction

    function automatic int m_tail(int w);
        return (m_head + q.size() + w) % DEPTH;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        dis_valid = '0; dis_arn = '0; dis_prn = '0; dis_reg_write = '0; dis_is_branch = '0;
        dis_pc = '0; dis_pred_taken = '0; dis_pred_target = '0;
        cdb_valid = '0; cdb_idx = '0; cdb_taken = '0; cdb_target = '0;
    endtask

    task automatic set_dis_way(int w, logic [4:0] arn, logic [5:0] prn, bit rw, bit br,
                               logic [31:0] pc, bit pt, logic [31:0] ptg);
        dis_valid[w] = 1'b1;
        dis_arn[w*ARN_W +: ARN_W] = arn;
        dis_prn[w*PRN_W +: PRN_W] = prn;
        dis_reg_write[w] = rw;
        dis_is_branch[w] = br;
        dis_pc[w*XLEN +: XLEN] = pc;
        dis_pred_taken[w] = pt;
        dis_pred_target[w*XLEN +: XLEN] = ptg;
    endtask

    task automatic set_cdb(int w, int idx, bit t, logic [31:0] tg);
        cdb_valid[w] = 1'b1;
        cdb_idx[w*IDX_W +: IDX_W] = IDX_W'(idx);
        cdb_taken[w] = t;
        cdb_target[w*XLEN +: XLEN] = tg;
    endtask

    // Directed dispatch: fields derived from the slot so retire data is traceable.
    task automatic dir_dis(int n, bit br0);
        int t;
        for (int w = 0; w < n; w++) begin
            t = m_tail(w);
            set_dis_way(w, 5'(t + 1), 6'(t + 8), 1'b1, (w == 0) && br0,
                        32'h1000 + 32'(4 * t), 1'b0, 32'h0);
        end
    endtask

    // Oldest-first: retire finished instructions, stop at a wrong-path branch.
    task automatic compute_expect();
        e_ret = '0; e_nret = 0; e_flush = 1'b0; e_fpc = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (k >= q.size() || !q[k].done) break;
            e_ret[k] = 1'b1;
            e_nret++;
            if (q[k].br && ((q[k].at != q[k].pt) || (q[k].at && q[k].atg != q[k].ptg))) begin
                e_flush = 1'b1;
                e_fpc   = q[k].at ? q[k].atg : q[k].pc + 32'd4;
                break;
            end
        end
    endtask

    task automatic sample_check();
        @(negedge clock);
        compute_expect();
        chk("ret_valid", 64'(ret_valid), 64'(e_ret));
        for (int k = 0; k < WAYS; k++) begin
            if (e_ret[k]) begin
                chk("ret_arn", 64'(ret_arn[k*ARN_W +: ARN_W]), 64'(q[k].arn));
                chk("ret_prn", 64'(ret_prn[k*PRN_W +: PRN_W]), 64'(q[k].prn));
                chk("ret_reg_write", 64'(ret_reg_write[k]), 64'(q[k].rw));
            end
        end
        chk("flush", 64'(flush), 64'(e_flush));
        chk("flush_pc", 64'(flush_pc), 64'(e_fpc));
        chk("num_free", 64'(num_free), 64'(DEPTH - q.size()));
        for (int w = 0; w < WAYS; w++) begin
            chk("dis_idx", 64'(dis_idx[w*IDX_W +: IDX_W]), 64'(m_tail(w)));
        end
    endtask

    task automatic advance();
        int     tail;
        m_ent_t e;
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_head = 0;
        end else if (e_flush) begin
            m_head = (m_head + e_nret) % DEPTH;
            q.delete();
        end else begin
            tail = m_tail(0);
            for (int w = 0; w < WAYS; w++) begin
                if (cdb_valid[w]) begin
                    foreach (q[j]) begin
                        if (q[j].idx == int'(cdb_idx[w*IDX_W +: IDX_W])) begin
                            q[j].done = 1'b1;
                            q[j].at   = cdb_taken[w];
                            q[j].atg  = cdb_target[w*XLEN +: XLEN];
                        end
                    end
                end
            end
            for (int k = 0; k < e_nret; k++) void'(q.pop_front());
            m_head = (m_head + e_nret) % DEPTH;
            for (int w = 0; w < WAYS; w++) begin
                if (dis_valid[w]) begin
                    e.idx = (tail + w) % DEPTH;
                    e.arn = dis_arn[w*ARN_W +: ARN_W];
                    e.prn = dis_prn[w*PRN_W +: PRN_W];
                    e.rw  = dis_reg_write[w];
                    e.br  = dis_is_branch[w];
                    e.pc  = dis_pc[w*XLEN +: XLEN];
                    e.pt  = dis_pred_taken[w];
                    e.ptg = dis_pred_target[w*XLEN +: XLEN];
                    e.done = 1'b0; e.at = 1'b0; e.atg = '0;
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        int nfree, nd, k, j;
        bit t;
        logic [31:0] tg;
        int pend[$];

        //        rst nd br c0v c0i t  c0g    c1v c1i eret  free fl fpc
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        for (int r = 0; r < 16; r++)
            tbl.push_back(mk(0, 2, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32 - 2 * r, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 2'b00, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b01, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 0, 32'h0, 0, 0, 2'b00, 1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0, 0, 0, 2'b00, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b11, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 2, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 2, 0, 32'h0));
        // Mispredicted branch at the head with a completed younger entry behind it.
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'h100, 1, 1, 2'b00, 30, 0, 32'h0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 32'h0, 0, 0, 2'b01, 30, 1, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        // Ten live entries, then reset with a completion on the same edge.
        for (int r = 0; r < 5; r++)
            tbl.push_back(mk(0, 2, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32 - 2 * r, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 2'b00, 22, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 31, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 2'b00, 31, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b01, 31, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'b00, 32, 0, 32'h0));

        clear_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (tbl[r]) begin
            clear_in();
            reset = tbl[r].rst;
            if (tbl[r].ndis > 0) dir_dis(tbl[r].ndis, tbl[r].br0);
            if (tbl[r].c0v) set_cdb(0, tbl[r].c0i, tbl[r].c0t, tbl[r].c0g);
            if (tbl[r].c1v) set_cdb(1, tbl[r].c1i, 1'b0, 32'h0);
            sample_check();
            chk("tbl_ret_valid", 64'(ret_valid), 64'(tbl[r].eret));
            chk("tbl_num_free", 64'(num_free), 64'(tbl[r].efree));
            chk("tbl_flush", 64'(flush), 64'(tbl[r].efl));
            if (tbl[r].efl) chk("tbl_flush_pc", 64'(flush_pc), 64'(tbl[r].efpc));
            advance();
        end
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            clear_in();
            reset = ($urandom_range(0, 399) == 0);
            nfree = DEPTH - q.size();
            nd = $urandom_range(0, WAYS);
            if (nd > nfree) nd = nfree;
            for (int w = 0; w < nd; w++) begin
                set_dis_way(w, 5'($urandom), 6'($urandom), 1'($urandom),
                            ($urandom_range(0, 3) == 0), 32'($urandom) & 32'hFFFF_FFFC,
                            1'($urandom), ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h200);
            end
            pend.delete();
            foreach (q[i]) if (!q[i].done) pend.push_back(i);
            for (int w = 0; w < WAYS; w++) begin
                if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, pend.size() - 1);
                    j = pend[k];
                    pend.delete(k);
                    t  = ($urandom_range(0, 7) == 0) ? !q[j].pt : q[j].pt;
                    tg = ($urandom_range(0, 7) == 0) ? 32'h300 : q[j].ptg;
                    set_cdb(w, q[j].idx, t, tg);
                end
            end
            sample_check();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
